core_bus_arbiter: RTL and testbench
===================================

# core_bus_arbiter

Merges the core's instruction bus and data bus into the single memory-side bus port, directly downstream of the pipeline top's `ireq`/`dreq` outputs. Accepts one request at a time, holds it in a latch register, and drives it to memory until the memory side signals the final beat. The result then returns to the originating port with a one-cycle `data_ok` pulse. Data-bus requests win conflicts by default, so a stalled memory stage never waits behind a fetch.

## Interface
Parameters:
- none; all widths fixed by the bus definitions in `common`.

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `reset`  in  1  — asynchronous, active-low; low forces IDLE immediately.
- `ireq_valid`  in  1  — fetch request pending; held until `iresp_addr_ok`.
- `ireq_addr`  in  64  — fetch address.
- `iresp_addr_ok`  out  1  — fetch request accepted this cycle.
- `iresp_data_ok`  out  1  — fetch data valid this cycle (one-cycle pulse).
- `iresp_data`  out  32  — instruction word.
- `dreq_valid`  in  1  — data request pending; held until `dresp_addr_ok`.
- `dreq_addr`  in  64  — data address.
- `dreq_size`  in  3  — access size code, passed through.
- `dreq_strobe`  in  8  — byte write enables; all-zero means read.
- `dreq_data`  in  64  — store data.
- `dresp_addr_ok`  out  1  — data request accepted this cycle.
- `dresp_data_ok`  out  1  — data result valid this cycle (one-cycle pulse).
- `dresp_data`  out  64  — load data.
- `oreq_valid`  out  1  — memory request valid.
- `oreq_is_write`  out  1  — request is a write.
- `oreq_size`  out  3  — access size code.
- `oreq_addr`  out  64  — request address.
- `oreq_strobe`  out  8  — byte write enables.
- `oreq_data`  out  64  — write data.
- `oresp_ready`  in  1  — memory beat completes this cycle.
- `oresp_last`  in  1  — completing beat is the final beat.
- `oresp_data`  in  64  — read data.

## Operation
- **States:** IDLE, IBUSY, DBUSY.
- **IDLE, `dreq_valid`=1:**
  - Assert `dresp_addr_ok` combinationally.
  - Latch addr, size, strobe and data.
  - Next state DBUSY.
- **IDLE, only `ireq_valid`=1:**
  - Assert `iresp_addr_ok`.
  - Latch addr; size = 3'b010, strobe = 0.
  - Next state IBUSY.
- **IDLE, neither valid:** stay in IDLE; all outputs 0.
- **IBUSY / DBUSY:**
  - `oreq_valid`=1 with the latched fields; `oreq_is_write` = |latched strobe.
  - Outputs are stable until completion.
- **Completion:** `oresp_ready` && `oresp_last`.
  - Pulse the owner's `data_ok` in that same cycle.
  - Next state IDLE.
- **Non-last beats:** `oresp_ready` without `oresp_last` is ignored, and the FSM keeps waiting.
- **Returned data:**
  - `iresp_data` = latched addr[2] ? `oresp_data`[63:32] : `oresp_data`[31:0].
  - `dresp_data` = `oresp_data`, unmodified.
  - When the corresponding `data_ok` is low, the data output is 0.
- **Ignored inputs:**
  - Requester inputs in BUSY states are ignored; no `addr_ok` is given.
  - A request dropped after `addr_ok` has no effect.
  - `oresp_*` in IDLE is ignored.

## Timing
- **Reset values:** all outputs 0 while reset is low; state IDLE; latch registers 0.
- **Accept:** `addr_ok` is issued in cycle N, the cycle of the request. `oreq_valid` rises at N+1.
- **Minimum latency:** `oresp_ready`&&`oresp_last` at N+1 gives `data_ok` at N+1, so 2 cycles request-to-data.
- **Back-to-back:** the FSM re-enters IDLE at completion+1. The next accept can occur in that cycle, so there is one bubble between memory transactions.
- **Simultaneous valid requests in IDLE:** resolved per Configuration; the loser keeps `valid` and is granted in a later IDLE cycle.
- **Reset mid-transaction:**
  - Outputs drop asynchronously, and the in-flight memory transaction is abandoned.
  - No `data_ok` is issued for it after reset releases.

## Configuration
- **`ARB_ROUND_ROBIN_EN` defined:**
  - A 1-bit `last_grant` register (reset 0 = data) is updated on every accept.
  - When both requests are valid in IDLE, the port not granted last wins.
  - A single valid request is granted regardless of `last_grant`.
- **`ARB_ROUND_ROBIN_EN` not defined:** fixed priority, data over instruction; no `last_grant` register.

## Test plan
- **Fetch read:** `ireq_valid`=1, addr=0x8000_0004; memory answers at N+2 with `oresp_data`=0x1111_2222_3333_4444, last=1. Expect `iresp_addr_ok` at N, `iresp_data_ok` at N+2 with `iresp_data`=0x1111_2222.
- **Store:** `dreq_valid`=1, addr=0x8000_1000, strobe=0xFF, data=0xDEAD_BEEF_0000_0001. Expect `oreq_is_write`=1 with all fields matching from N+1, and `dresp_data_ok` exactly on the ready&&last cycle.
- **Conflict, fixed priority:** both valid in the same IDLE cycle. Expect the data request served first and the fetch accepted in the IDLE cycle after completion. With `ARB_ROUND_ROBIN_EN`, run two consecutive conflicts and expect the grant order data, fetch, data, fetch.
- **Multi-beat:** `oresp_ready`=1 with last=0 for 3 cycles, then last=1. Expect exactly one `data_ok` pulse, carrying the last beat's data.
- **Reset mid-transaction:** assert reset low in DBUSY between clock edges. Expect `oreq_valid`=0 immediately and no `dresp_data_ok` after release; a new `ireq` is accepted normally.
- **Idle noise:** `oresp_ready`=1 in IDLE with no requests. Expect all `*_ok` outputs to stay 0 and the state to stay IDLE.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges the core's fetch and data buses onto one memory port.
// Optional: define ARB_ROUND_ROBIN_EN for alternating grants on conflicts.
module core_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        oreq_valid,
    output logic        oreq_is_write,
    output logic [2:0]  oreq_size,
    output logic [63:0] oreq_addr,
    output logic [7:0]  oreq_strobe,
    output logic [63:0] oreq_data,
    input  logic        oresp_ready,
    input  logic        oresp_last,
    input  logic [63:0] oresp_data
);

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] lat_addr;
    logic [63:0] lat_data;
    logic [2:0]  lat_size;
    logic [7:0]  lat_strobe;
    logic        prefer_d;
    logic        grant_d;
    logic        grant_i;
    logic        busy;
    logic        done;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    // remember who won the last accept: 0 = data, 1 = fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b0;
        end else if (grant_d) begin
            last_grant <= 1'b0;
        end else if (grant_i) begin
            last_grant <= 1'b1;
        end
    end

    assign prefer_d = last_grant;
`else
    assign prefer_d = 1'b1;
`endif

    assign grant_d = reset && (state == IDLE) && dreq_valid
                     && (!ireq_valid || prefer_d);
    assign grant_i = reset && (state == IDLE) && ireq_valid && !grant_d;

    assign busy = (state != IDLE);
    assign done = busy && oresp_ready && oresp_last;

    // state register; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and request acceptance
    always_comb begin
        state_nxt     = state;
        dresp_addr_ok = 1'b0;
        iresp_addr_ok = 1'b0;
        unique case (state)
            IDLE: begin
                dresp_addr_ok = grant_d;
                iresp_addr_ok = grant_i;
                unique case (1'b1)
                    grant_d: state_nxt = DBUSY;
                    grant_i: state_nxt = IBUSY;
                    default: state_nxt = IDLE;
                endcase
            end
            IBUSY, DBUSY: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // capture the accepted request; fetches are always 32-bit reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_addr   <= 64'h0;
            lat_data   <= 64'h0;
            lat_size   <= 3'b000;
            lat_strobe <= 8'h00;
        end else if (grant_d) begin
            lat_addr   <= dreq_addr;
            lat_data   <= dreq_data;
            lat_size   <= dreq_size;
            lat_strobe <= dreq_strobe;
        end else if (grant_i) begin
            lat_addr   <= ireq_addr;
            lat_data   <= 64'h0;
            lat_size   <= 3'b010;
            lat_strobe <= 8'h00;
        end
    end

    assign oreq_valid    = busy;
    assign oreq_is_write = busy && (|lat_strobe);
    assign oreq_size     = busy ? lat_size : 3'b000;
    assign oreq_addr     = busy ? lat_addr : 64'h0;
    assign oreq_strobe   = busy ? lat_strobe : 8'h00;
    assign oreq_data     = busy ? lat_data : 64'h0;

    assign iresp_data_ok = done && (state == IBUSY);
    assign dresp_data_ok = done && (state == DBUSY);

    assign iresp_data = !iresp_data_ok ? 32'h0 :
                        lat_addr[2] ? oresp_data[63:32] : oresp_data[31:0];
    assign dresp_data = dresp_data_ok ? oresp_data : 64'h0;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: scoreboard bench for core_bus_arbiter.
// Honours ARB_ROUND_ROBIN_EN when predicting conflict winners.
module tb_core_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        oreq_valid;
    logic        oreq_is_write;
    logic [2:0]  oreq_size;
    logic [63:0] oreq_addr;
    logic [7:0]  oreq_strobe;
    logic [63:0] oreq_data;
    logic        oresp_ready;
    logic        oresp_last;
    logic [63:0] oresp_data;

    typedef struct packed {
        logic        d;
        logic [63:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;
    logic lg_m = 1'b0;

    core_bus_arbiter dut (
        .clk(clk),
        .reset(reset),
        .ireq_valid(ireq_valid),
        .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data(iresp_data),
        .dreq_valid(dreq_valid),
        .dreq_addr(dreq_addr),
        .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data),
        .oreq_valid(oreq_valid),
        .oreq_is_write(oreq_is_write),
        .oreq_size(oreq_size),
        .oreq_addr(oreq_addr),
        .oreq_strobe(oreq_strobe),
        .oreq_data(oreq_data),
        .oresp_ready(oresp_ready),
        .oresp_last(oresp_last),
        .oresp_data(oresp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ifetch(input logic [63:0] a,
                                           input logic [63:0] r);
        return a[2] ? {32'h0, r[63:32]} : {32'h0, r[31:0]};
    endfunction

    // pop one expectation per data_ok; idle data must read zero
    always @(negedge clk) begin
        exp_t e;
        if (!iresp_data_ok) check("i_data_idle", iresp_data, 0);
        if (!dresp_data_ok) check("d_data_idle", dresp_data, 0);
        if (iresp_data_ok || dresp_data_ok) begin
            if (sb.size() == 0) begin
                check("unexp_ok", 1, 0);
            end else begin
                e = sb.pop_front();
                check("ok_both", iresp_data_ok & dresp_data_ok, 0);
                check("ok_port", dresp_data_ok, e.d);
                check("rdata", e.d ? dresp_data : {32'h0, iresp_data}, e.v);
            end
        end
    end

    task automatic chk_oreq(input logic w, input logic [2:0] sz,
                            input logic [63:0] a, input logic [7:0] st,
                            input logic [63:0] wd);
        check("oreq_valid", oreq_valid, 1);
        check("oreq_wr", oreq_is_write, w);
        check("oreq_size", oreq_size, sz);
        check("oreq_addr", oreq_addr, a);
        check("oreq_strb", oreq_strobe, st);
        check("oreq_data", oreq_data, wd);
    endtask

    task automatic mem_resp(input int gap, input int nl,
                            input logic [63:0] rdata, input logic e_d,
                            input logic [63:0] e_data, input logic e_w,
                            input logic [2:0] e_sz, input logic [63:0] e_a,
                            input logic [7:0] e_st, input logic [63:0] e_wd);
        repeat (gap) begin
            @(negedge clk);
            chk_oreq(e_w, e_sz, e_a, e_st, e_wd);
            check("busy_aok", iresp_addr_ok | dresp_addr_ok, 0);
            tick();
        end
        for (int i = 0; i < nl; i++) begin
            oresp_ready = 1'b1;
            oresp_last  = 1'b0;
            oresp_data  = {$urandom, $urandom};
            @(negedge clk);
            chk_oreq(e_w, e_sz, e_a, e_st, e_wd);
            tick();
        end
        oresp_ready = 1'b1;
        oresp_last  = 1'b1;
        oresp_data  = rdata;
        sb.push_back('{e_d, e_data});
        @(negedge clk);
        chk_oreq(e_w, e_sz, e_a, e_st, e_wd);
        #1;
        check("pulse", sb.size(), 0);
        tick();
        oresp_ready = 1'b0;
        oresp_last  = 1'b0;
        oresp_data  = 64'h0;
        @(negedge clk);
        check("idle_ret", oreq_valid, 0);
    endtask

    task automatic serve_i(input logic [63:0] a, input int gap, input int nl);
        logic [63:0] r;
        r = {$urandom, $urandom};
        mem_resp(gap, nl, r, 1'b0, ifetch(a, r), 1'b0, 3'b010, a, 8'h0, 64'h0);
    endtask

    task automatic serve_d(input logic [63:0] a, input logic [2:0] sz,
                           input logic [7:0] st, input logic [63:0] wd,
                           input int gap, input int nl);
        logic [63:0] r;
        r = {$urandom, $urandom};
        mem_resp(gap, nl, r, 1'b1, r, |st, sz, a, st, wd);
    endtask

    task automatic req_i(input logic [63:0] a);
        tick();
        ireq_valid = 1'b1;
        ireq_addr  = a;
        @(negedge clk);
        check("i_aok", iresp_addr_ok, 1);
        check("i_dok_x", dresp_addr_ok, 0);
        lg_m = 1'b1;
        tick();
        ireq_valid = 1'b0;
    endtask

    task automatic req_d(input logic [63:0] a, input logic [2:0] sz,
                         input logic [7:0] st, input logic [63:0] wd);
        tick();
        dreq_valid  = 1'b1;
        dreq_addr   = a;
        dreq_size   = sz;
        dreq_strobe = st;
        dreq_data   = wd;
        @(negedge clk);
        check("d_aok", dresp_addr_ok, 1);
        check("d_iok_x", iresp_addr_ok, 0);
        lg_m = 1'b0;
        tick();
        dreq_valid = 1'b0;
    endtask

    task automatic conflict(input logic [63:0] ia, input logic [63:0] da);
        logic wd;
`ifdef ARB_ROUND_ROBIN_EN
        wd = lg_m;
`else
        wd = 1'b1;
`endif
        tick();
        ireq_valid  = 1'b1;
        ireq_addr   = ia;
        dreq_valid  = 1'b1;
        dreq_addr   = da;
        dreq_size   = 3'b011;
        dreq_strobe = 8'h00;
        dreq_data   = 64'h0123;
        @(negedge clk);
        check("cf_d_aok", dresp_addr_ok, wd);
        check("cf_i_aok", iresp_addr_ok, !wd);
        tick();
        if (wd) begin
            dreq_valid = 1'b0;
            lg_m = 1'b0;
            serve_d(da, 3'b011, 8'h00, 64'h0123, 1, 0);
            check("cf_i_late", iresp_addr_ok, 1);
            tick();
            ireq_valid = 1'b0;
            lg_m = 1'b1;
            serve_i(ia, 1, 0);
        end else begin
            ireq_valid = 1'b0;
            lg_m = 1'b1;
            serve_i(ia, 1, 0);
            check("cf_d_late", dresp_addr_ok, 1);
            tick();
            dreq_valid = 1'b0;
            lg_m = 1'b0;
            serve_d(da, 3'b011, 8'h00, 64'h0123, 1, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        ireq_valid  = 1'b1;
        ireq_addr   = 64'h8000_0000;
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h8000_0100;
        dreq_size   = 3'b011;
        dreq_strobe = 8'hFF;
        dreq_data   = 64'h55;
        oresp_ready = 1'b1;
        oresp_last  = 1'b1;
        oresp_data  = 64'hFFFF;
        repeat (2) @(negedge clk);
        check("rst_i_aok", iresp_addr_ok, 0);
        check("rst_d_aok", dresp_addr_ok, 0);
        check("rst_oreq", oreq_valid, 0);
        check("rst_wr", oreq_is_write, 0);
        check("rst_addr", oreq_addr, 0);
        ireq_valid  = 1'b0;
        dreq_valid  = 1'b0;
        oresp_ready = 1'b0;
        oresp_last  = 1'b0;
        oresp_data  = 64'h0;
        reset = 1'b1;

        req_i(64'h8000_0004);
        mem_resp(1, 0, 64'h1111_2222_3333_4444, 1'b0, 64'h1111_2222,
                 1'b0, 3'b010, 64'h8000_0004, 8'h0, 64'h0);

        req_i(64'h8000_0000);
        serve_i(64'h8000_0000, 0, 0);

        req_d(64'h8000_1000, 3'b011, 8'hFF, 64'hDEAD_BEEF_0000_0001);
        serve_d(64'h8000_1000, 3'b011, 8'hFF, 64'hDEAD_BEEF_0000_0001, 2, 0);

        req_d(64'h8000_2008, 3'b010, 8'h00, 64'h0);
        serve_d(64'h8000_2008, 3'b010, 8'h00, 64'h0, 0, 3);

        req_d(64'h8000_3000, 3'b010, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD);
        serve_d(64'h8000_3000, 3'b010, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0);

        req_i(64'h8000_0014);
        serve_i(64'h8000_0014, 0, 2);

        conflict(64'h8000_0040, 64'h8000_4000);
        conflict(64'h8000_0044, 64'h8000_4008);

        req_d(64'h8000_5000, 3'b011, 8'h0F, 64'h1234);
        @(negedge clk);
        check("mid_busy", oreq_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_oreq", oreq_valid, 0);
        check("mid_wr", oreq_is_write, 0);
        check("mid_addr", oreq_addr, 0);
        lg_m = 1'b0;
        tick();
        oresp_ready = 1'b1;
        oresp_last  = 1'b1;
        oresp_data  = 64'h77;
        @(negedge clk);
        check("mid_dok_rst", dresp_data_ok, 0);
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("mid_dok_rel", dresp_data_ok, 0);
        check("mid_idle", oreq_valid, 0);
        tick();
        oresp_ready = 1'b0;
        oresp_last  = 1'b0;
        oresp_data  = 64'h0;
        req_i(64'h8000_0008);
        serve_i(64'h8000_0008, 0, 0);

        tick();
        oresp_ready = 1'b1;
        oresp_last  = 1'b1;
        oresp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            check("nz_i_aok", iresp_addr_ok, 0);
            check("nz_d_aok", dresp_addr_ok, 0);
            check("nz_i_dok", iresp_data_ok, 0);
            check("nz_d_dok", dresp_data_ok, 0);
            check("nz_oreq", oreq_valid, 0);
            tick();
        end
        oresp_ready = 1'b0;
        oresp_last  = 1'b0;
        oresp_data  = 64'h0;

        req_d(64'h8000_6000, 3'b011, 8'h00, 64'h0);
        serve_d(64'h8000_6000, 3'b011, 8'h00, 64'h0, 0, 0);

        tick();
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
